// File: rtl/realtanksoc_bus_pkg.sv
// Shared AHB-Lite encodings and the address-phase bundle used by the
// RealTankSoC bus matrix stages.
package realtanksoc_bus_pkg;

  localparam logic [1:0] TRN_IDLE   = 2'b00;
  localparam logic [1:0] TRN_BUSY   = 2'b01;
  localparam logic [1:0] TRN_NONSEQ = 2'b10;
  localparam logic [1:0] TRN_SEQ    = 2'b11;

  localparam logic [2:0] BUR_SINGLE = 3'd0;
  localparam logic [2:0] BUR_INCR   = 3'd1;
  localparam logic [2:0] BUR_WRAP4  = 3'd2;
  localparam logic [2:0] BUR_INCR4  = 3'd3;
  localparam logic [2:0] BUR_WRAP8  = 3'd4;
  localparam logic [2:0] BUR_INCR8  = 3'd5;
  localparam logic [2:0] BUR_WRAP16 = 3'd6;
  localparam logic [2:0] BUR_INCR16 = 3'd7;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Field order matches the ADDR_O..MASTLOCK_O output concatenation.
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        mastlock;
  } ahb_aphase_t;

  // NONSEQ and SEQ both have HTRANS[1] set; IDLE and BUSY do not.
  function automatic logic is_active_trans(input logic [1:0] t);
    return t[1];
  endfunction

endpackage

// File: rtl/realtanksoc_bus_in_stage.sv
// Per-master AHB-Lite input stage of the bus matrix.
// Forwards a master address phase straight through when the target output
// stage takes it in the same cycle; otherwise captures it, stalls the master
// and replays the held copy until taken. Routes the data-phase response back.
// Ports:
//   HCLK, HRESET (async, active-high)
//   HSELS..HMASTLOCKS, HREADYS : master-side address phase / system HREADY
//   HREADYOUTS, HRESPS         : data-phase ready / response to the master
//   ADDR_O..MASTLOCK_O, sel_o  : address phase toward decoder / output stages
//   trans_req_o                : active NONSEQ/SEQ request (live or held)
//   active_i                   : selected output stage takes this port now
//   readyout_i, resp_i         : selected output stage data-phase response
module realtanksoc_bus_in_stage
  import realtanksoc_bus_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic [2:0]  HBURSTS,
  input  logic [3:0]  HPROTS,
  input  logic        HMASTLOCKS,
  input  logic        HREADYS,
  output logic        HREADYOUTS,
  output logic        HRESPS,
  output logic [31:0] ADDR_O,
  output logic [1:0]  TRANS_O,
  output logic        WRITE_O,
  output logic [2:0]  SIZE_O,
  output logic [2:0]  BURST_O,
  output logic [3:0]  PROT_O,
  output logic        MASTLOCK_O,
  output logic        sel_o,
  output logic        trans_req_o,
  input  logic        active_i,
  input  logic        readyout_i,
  input  logic        resp_i
);

  ahb_aphase_t live, hold, aph;
  logic        pend, dphase;
  logic        samp, req_live, fwd, capture;

  assign live     = {HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS};
  assign samp     = HSELS & HREADYS;
  assign req_live = samp & is_active_trans(HTRANSS);

  // While a transfer is held the master is stalled (HREADYOUTS=0), so the
  // live inputs are ignored and only the held copy can be taken.
  assign fwd      = pend ? active_i : (req_live & active_i);
  assign capture  = ~pend & req_live & ~active_i;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pend   <= 1'b0;
      dphase <= 1'b0;
      hold   <= '0;
    end else begin
      if (capture) hold <= live;

      if (pend & active_i) pend <= 1'b0;
      else if (capture)    pend <= 1'b1;

      // A newly taken transfer keeps the data phase open even when the
      // previous one completes in the same cycle.
      if (fwd)                                        dphase <= 1'b1;
      else if (samp & ~is_active_trans(HTRANSS))      dphase <= 1'b0;
      else if (readyout_i)                            dphase <= 1'b0;
    end
  end

  assign aph         = pend ? hold : live;
  assign {ADDR_O, TRANS_O, WRITE_O, SIZE_O, BURST_O, PROT_O, MASTLOCK_O} = aph;
  assign sel_o       = pend | samp;
  assign trans_req_o = pend | req_live;

  // Only registered state and the output stage response reach the master;
  // active_i never feeds HREADYOUTS combinationally.
  assign HREADYOUTS  = dphase ? readyout_i : ~pend;
  assign HRESPS      = dphase ? resp_i     : HRESP_OKAY;

endmodule
